mod_div_sequencer: RTL and testbench

MOD_DIV_SEQUENCER -- requirements
Module: mod_div_sequencer

---
 rtl/mod_div_sequencer_if.sv | 22 ++
 rtl/mod_div_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mod_div_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_div_sequencer_if.sv
// Handshake and result bundle for mod_div_sequencer.
// master: requester (drives start/x/y); slave: the divider.
interface mod_div_sequencer_if;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        busy;
  logic        done;
  logic [15:0] rem_out;
  logic [15:0] quo_out;
  logic        div0;

  modport master (
    output start, x, y,
    input  busy, done, rem_out, quo_out, div0
  );

  modport slave (
    input  start, x, y,
    output busy, done, rem_out, quo_out, div0
  );
endinterface

// File: rtl/mod_div_sequencer.sv
// Sequential 16-bit restoring divider producing x / y and x mod y.
// One quotient bit per clock, MSB first; results land on the outputs only when
// the DONE state is entered. Divide-by-zero finishes in one cycle with div0 set.
// Build option: define MOD_SIGNED_EN for two's-complement (truncating) division,
// which adds a one-cycle FIXUP state that applies the result signs.
module mod_div_sequencer (
  input  logic               clk,
  input  logic               rst_n,
  mod_div_sequencer_if.slave bus
);

`ifdef MOD_SIGNED_EN
  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [15:0] rem_q, rem_d;     // partial remainder
  logic [15:0] dvs_q, dvs_d;     // divisor (magnitude in the signed build)
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;
  logic [15:0] rem_out_q, rem_out_d;
  logic [15:0] quo_out_q, quo_out_d;
`ifdef MOD_SIGNED_EN
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
`endif

  logic        accept;
  logic [16:0] diff;
  logic [15:0] step_rem;
  logic [15:0] step_quo;

  // A request is taken only from the non-busy states
  assign accept = bus.start && (state_q == StIdle || state_q == StDone);

  // One restoring step: shift in next dividend bit, trial-subtract, restore on borrow
  assign diff     = {rem_q, dvd_q[15]} - {1'b0, dvs_q};
  assign step_rem = diff[16] ? {rem_q[14:0], dvd_q[15]} : diff[15:0];
  assign step_quo = {dvd_q[14:0], ~diff[16]};

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      rem_out_q <= '0;
      quo_out_q <= '0;
`ifdef MOD_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      rem_out_q <= rem_out_d;
      quo_out_q <= quo_out_d;
`ifdef MOD_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = (bus.y == 16'd0) ? StDone : StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        if (cnt_q == 5'd15) begin
`ifdef MOD_SIGNED_EN
          state_d = StFixup;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef MOD_SIGNED_EN
      StFixup: state_d = StDone;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Datapath and next values of the registered outputs
  always_comb begin
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    div0_d    = div0_q;
    rem_out_d = rem_out_q;
    quo_out_d = quo_out_q;
`ifdef MOD_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);

    if (accept) begin
      cnt_d = '0;
      rem_d = '0;
`ifdef MOD_SIGNED_EN
      dvd_d     = bus.x[15] ? (~bus.x + 16'd1) : bus.x;
      dvs_d     = bus.y[15] ? (~bus.y + 16'd1) : bus.y;
      neg_quo_d = bus.x[15] ^ bus.y[15];
      neg_rem_d = bus.x[15];
`else
      dvd_d = bus.x;
      dvs_d = bus.y;
`endif
      if (bus.y == 16'd0) begin
        div0_d    = 1'b1;
        rem_out_d = bus.x;
        quo_out_d = 16'hFFFF;
      end
    end else if (state_q == StCalc) begin
      cnt_d = cnt_q + 5'd1;
      rem_d = step_rem;
      dvd_d = step_quo;
`ifndef MOD_SIGNED_EN
      if (cnt_q == 5'd15) begin
        div0_d    = 1'b0;
        rem_out_d = step_rem;
        quo_out_d = step_quo;
      end
`endif
    end
`ifdef MOD_SIGNED_EN
    else if (state_q == StFixup) begin
      div0_d    = 1'b0;
      quo_out_d = neg_quo_q ? (~dvd_q + 16'd1) : dvd_q;
      rem_out_d = neg_rem_q ? (~rem_q + 16'd1) : rem_q;
    end
`endif
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.div0    = div0_q;
  assign bus.rem_out = rem_out_q;
  assign bus.quo_out = quo_out_q;

endmodule

// File: tb/tb_mod_div_sequencer.sv
// Directed bench for mod_div_sequencer: vector table plus hand sequences for
// ignored start, back-to-back operation and reset abort.
module tb_mod_div_sequencer;

`ifdef MOD_SIGNED_EN
  localparam int Lat = 18;
`else
  localparam int Lat = 17;
`endif

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] rem;
    logic [15:0] quo;
    logic        div0;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mod_div_sequencer_if bus_if ();

  mod_div_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic [15:0] rem,
                              input logic [15:0] quo, input logic div0, input int lat);
    vec_t v;
    v.x = x; v.y = y; v.rem = rem; v.quo = quo; v.div0 = div0; v.lat = lat;
    return v;
  endfunction

  // Pulse start for one cycle, then count cycles until done (bounded).
  // Operand inputs are scrambled while busy to show they were latched.
  task automatic run_op(input logic [15:0] xv, input logic [15:0] yv,
                        output int lat, output int busy_cnt);
    bus_if.x     = xv;
    bus_if.y     = yv;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!bus_if.done && lat < 40) begin
      if (bus_if.busy) busy_cnt++;
      bus_if.x = 16'($urandom);
      bus_if.y = 16'($urandom);
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[$];
  int   lat;
  int   bcnt;
  int   pulses;

  initial begin
    errors = 0;
    checks = 0;

`ifdef MOD_SIGNED_EN
    vecs.push_back(mk(16'd100,   16'd7,     16'd2,     16'd14,    1'b0, 18));
    vecs.push_back(mk(16'd5,     16'd0,     16'd5,     16'hFFFF,  1'b1, 1));
    vecs.push_back(mk(16'hFFF9,  16'd3,     16'hFFFF,  16'hFFFE,  1'b0, 18));
    vecs.push_back(mk(16'h8000,  16'hFFFF,  16'h0000,  16'h8000,  1'b0, 18));
    vecs.push_back(mk(16'd7,     16'hFFFD,  16'd1,     16'hFFFE,  1'b0, 18));
    vecs.push_back(mk(16'hFFF9,  16'hFFFD,  16'hFFFF,  16'd2,     1'b0, 18));
    vecs.push_back(mk(16'h0000,  16'h0000,  16'h0000,  16'hFFFF,  1'b1, 1));
`else
    vecs.push_back(mk(16'd100,   16'd7,     16'd2,     16'd14,    1'b0, 17));
    vecs.push_back(mk(16'd5,     16'd0,     16'd5,     16'hFFFF,  1'b1, 1));
    vecs.push_back(mk(16'hFFFF,  16'd1,     16'd0,     16'hFFFF,  1'b0, 17));
    vecs.push_back(mk(16'd7,     16'd100,   16'd7,     16'd0,     1'b0, 17));
    vecs.push_back(mk(16'hFFFF,  16'd256,   16'd255,   16'd255,   1'b0, 17));
    vecs.push_back(mk(16'd40000, 16'd3,     16'd1,     16'd13333, 1'b0, 17));
    vecs.push_back(mk(16'hFFFF,  16'hFFFF,  16'd0,     16'd1,     1'b0, 17));
    vecs.push_back(mk(16'd0,     16'd5,     16'd0,     16'd0,     1'b0, 17));
    vecs.push_back(mk(16'h0000,  16'h0000,  16'h0000,  16'hFFFF,  1'b1, 1));
`endif

    // Reset state
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.x     = '0;
    bus_if.y     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus_if.busy}, 32'd0);
    check("reset_done", {31'd0, bus_if.done}, 32'd0);
    check("reset_div0", {31'd0, bus_if.div0}, 32'd0);
    check("reset_rem",  {16'd0, bus_if.rem_out}, 32'd0);
    check("reset_quo",  {16'd0, bus_if.quo_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].x, vecs[i].y, lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat - 1);
      check($sformatf("v%0d_rem", i), {16'd0, bus_if.rem_out}, {16'd0, vecs[i].rem});
      check($sformatf("v%0d_quo", i), {16'd0, bus_if.quo_out}, {16'd0, vecs[i].quo});
      check($sformatf("v%0d_div0", i), {31'd0, bus_if.div0}, {31'd0, vecs[i].div0});
      check($sformatf("v%0d_busy_at_done", i), {31'd0, bus_if.busy}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), {31'd0, bus_if.done}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_rem_hold", i), {16'd0, bus_if.rem_out}, {16'd0, vecs[i].rem});
    end

    // Start re-asserted while busy must be ignored
    bus_if.x     = 16'hFFFF;
    bus_if.y     = 16'd1;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    lat = 1;
    while (!bus_if.done && lat < 40) begin
      if (lat == 4) begin
        bus_if.x     = 16'd9;
        bus_if.y     = 16'd4;
        bus_if.start = 1'b1;
      end
      if (lat == 6) bus_if.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("ignore_latency", lat, Lat);
    check("ignore_rem", {16'd0, bus_if.rem_out}, 32'd0);
    check("ignore_quo", {16'd0, bus_if.quo_out}, 32'h0000FFFF);
    @(negedge clk);
    check("ignore_no_requeue", {31'd0, bus_if.busy}, 32'd0);

    // Back-to-back: start held through the DONE cycle
    bus_if.x     = 16'd100;
    bus_if.y     = 16'd7;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.x = 16'd9;
    bus_if.y = 16'd4;
    lat = 1;
    while (!bus_if.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", lat, Lat);
    check("b2b_first_rem", {16'd0, bus_if.rem_out}, 32'd2);
    check("b2b_first_quo", {16'd0, bus_if.quo_out}, 32'd14);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus_if.start = 1'b0;
        check("b2b_second_busy", {31'd0, bus_if.busy}, 32'd1);
      end
    end while (!bus_if.done && lat < 40);
    check("b2b_second_latency", lat, Lat);
    check("b2b_second_rem", {16'd0, bus_if.rem_out}, 32'd1);
    check("b2b_second_quo", {16'd0, bus_if.quo_out}, 32'd2);
    @(negedge clk);

    // Reset in the middle of CALC aborts with no done pulse
    bus_if.x     = 16'd1000;
    bus_if.y     = 16'd3;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    check("abort_done", {31'd0, bus_if.done}, 32'd0);
    check("abort_div0", {31'd0, bus_if.div0}, 32'd0);
    check("abort_rem",  {16'd0, bus_if.rem_out}, 32'd0);
    check("abort_quo",  {16'd0, bus_if.quo_out}, 32'd0);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus_if.done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op(16'd10, 16'd3, lat, bcnt);
    check("after_abort_latency", lat, Lat);
    check("after_abort_rem", {16'd0, bus_if.rem_out}, 32'd1);
    check("after_abort_quo", {16'd0, bus_if.quo_out}, 32'd3);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
